// File: rtl/reg_file_32x32_if.sv
// Register-file access bundle: two read ports and one write port.
// The master drives addresses and write-back data; the slave returns read data.
interface reg_file_32x32_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              RegWrite;
   logic [ADDR_W-1:0] ReadReg1;
   logic [ADDR_W-1:0] ReadReg2;
   logic [ADDR_W-1:0] WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic [DATA_W-1:0] ReadData1;
   logic [DATA_W-1:0] ReadData2;

   modport master (
      output RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
      input  ReadData1, ReadData2
   );

   modport slave (
      input  RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
      output ReadData1, ReadData2
   );
endinterface

// File: rtl/reg_file_32x32.sv
// MIPS 32-entry register file: $0 is constant zero, $29 resets to SP_RESET.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_32x32 #(
   parameter int                 DATA_W   = 32,
   parameter int                 ADDR_W   = 5,
   parameter logic [DATA_W-1:0]  SP_RESET = 32'h00003FFC
) (
   input  logic                   clk,
   input  logic                   reset,
   reg_file_32x32_if.slave        rf
);
   localparam int NREGS  = 1 << ADDR_W;
   localparam int SP_IDX = 29;

   logic [DATA_W-1:0] regs_q [1:NREGS-1];
   logic              wr_en_s;
   logic [DATA_W-1:0] rdata1_s;
   logic [DATA_W-1:0] rdata2_s;

   assign wr_en_s = rf.RegWrite && (rf.WriteReg != '0);

   // Register storage; entry 0 has no flop and is never written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
         end
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (wr_en_s && (rf.WriteReg == ADDR_W'(i))) begin
               regs_q[i] <= rf.WriteData;
            end
         end
      end
   end

   // Combinational read muxes; address 0 falls through to the zero default.
   always_comb begin
      rdata1_s = '0;
      rdata2_s = '0;
      for (int i = 1; i < NREGS; i++) begin
         rdata1_s = (rf.ReadReg1 == ADDR_W'(i)) ? regs_q[i] : rdata1_s;
         rdata2_s = (rf.ReadReg2 == ADDR_W'(i)) ? regs_q[i] : rdata2_s;
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_en_s && !reset && (rf.WriteReg == rf.ReadReg1)) begin
         rdata1_s = rf.WriteData;
      end else begin
         rdata1_s = rdata1_s;
      end
      if (wr_en_s && !reset && (rf.WriteReg == rf.ReadReg2)) begin
         rdata2_s = rf.WriteData;
      end else begin
         rdata2_s = rdata2_s;
      end
`endif
   end

   assign rf.ReadData1 = rdata1_s;
   assign rf.ReadData2 = rdata2_s;
endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32 against an array-based reference model.
module tb_reg_file_32x32;
   localparam logic [31:0] SP_RST = 32'h00003FFC;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   logic [31:0] model [32];

   reg_file_32x32_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   reg_file_32x32 #(.DATA_W(32), .ADDR_W(5), .SP_RESET(SP_RST)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (bus)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? SP_RST : 32'h0;
   endfunction

   // Expected read value given the model contents and the inputs currently driven.
   function automatic logic [31:0] ref_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (bus.RegWrite && !reset && bus.WriteReg == a) return bus.WriteData;
`endif
      return model[a];
   endfunction

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.RegWrite = 1'b1; bus.WriteReg = a; bus.WriteData = d;
      @(posedge clk); #1;
      if (a != 5'd0) model[a] = d;
      bus.RegWrite = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.ReadReg1 = 5'd29; bus.ReadReg2 = 5'd5;
      #2;
      vectors++;
      if (bus.ReadData1 !== 32'h00003FFC) begin
         miscompares++; $display("FAIL reset_sp: got %h expected %h", bus.ReadData1, 32'h00003FFC);
      end
      vectors++;
      if (bus.ReadData2 !== 32'h0) begin
         miscompares++; $display("FAIL reset_r5: got %h expected %h", bus.ReadData2, 32'h0);
      end
      reset = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (bus.ReadData1 !== 32'h00003FFC) begin
         miscompares++; $display("FAIL reset_release_sp: got %h expected %h", bus.ReadData1, 32'h00003FFC);
      end
   endtask

   task automatic test_write_read();
      do_write(5'd8, 32'hDEADBEEF);
      bus.ReadReg1 = 5'd8; bus.ReadReg2 = 5'd8; #1;
      vectors++;
      if (bus.ReadData1 !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL wr_rd_p1: got %h expected %h", bus.ReadData1, 32'hDEADBEEF);
      end
      vectors++;
      if (bus.ReadData2 !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL wr_rd_p2: got %h expected %h", bus.ReadData2, 32'hDEADBEEF);
      end
   endtask

   task automatic test_zero_reg();
      do_write(5'd0, 32'hFFFFFFFF);
      bus.ReadReg1 = 5'd0; #1;
      vectors++;
      if (bus.ReadData1 !== 32'h0) begin
         miscompares++; $display("FAIL zero_reg: got %h expected %h", bus.ReadData1, 32'h0);
      end
   endtask

   task automatic test_no_write();
      do_write(5'd9, 32'h00000007);
      @(negedge clk);
      bus.RegWrite = 1'b0; bus.WriteReg = 5'd9; bus.WriteData = 32'h12345678;
      bus.ReadReg2 = 5'd9;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.ReadData2 !== 32'h00000007) begin
         miscompares++; $display("FAIL no_write: got %h expected %h", bus.ReadData2, 32'h00000007);
      end
   endtask

   task automatic test_collision();
      logic [31:0] exp_before;
`ifdef REGFILE_BYPASS_EN
      exp_before = 32'h00000055;
`else
      exp_before = 32'h00000001;
`endif
      do_write(5'd10, 32'h00000001);
      @(negedge clk);
      bus.RegWrite = 1'b1; bus.WriteReg = 5'd10; bus.WriteData = 32'h00000055;
      bus.ReadReg1 = 5'd10; #1;
      vectors++;
      if (bus.ReadData1 !== exp_before) begin
         miscompares++; $display("FAIL collide_before: got %h expected %h", bus.ReadData1, exp_before);
      end
      @(posedge clk); #1;
      model[10] = 32'h00000055;
      bus.RegWrite = 1'b0;
      #1;
      vectors++;
      if (bus.ReadData1 !== 32'h00000055) begin
         miscompares++; $display("FAIL collide_after: got %h expected %h", bus.ReadData1, 32'h00000055);
      end
   endtask

   task automatic test_async_reset();
      do_write(5'd3, 32'hA5A5A5A5);
      @(negedge clk); #2;
      bus.ReadReg1 = 5'd3; bus.ReadReg2 = 5'd29;
      bus.RegWrite = 1'b1; bus.WriteReg = 5'd3; bus.WriteData = 32'h5A5A5A5A;
      reset = 1'b1; #1;
      vectors++;
      if (bus.ReadData1 !== 32'h0) begin
         miscompares++; $display("FAIL async_rst_now: got %h expected %h", bus.ReadData1, 32'h0);
      end
      vectors++;
      if (bus.ReadData2 !== SP_RST) begin
         miscompares++; $display("FAIL async_rst_sp: got %h expected %h", bus.ReadData2, SP_RST);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.ReadData1 !== 32'h0) begin
         miscompares++; $display("FAIL async_rst_edge: got %h expected %h", bus.ReadData1, 32'h0);
      end
      @(negedge clk);
      reset = 1'b0; bus.RegWrite = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (bus.ReadData1 !== 32'h0) begin
         miscompares++; $display("FAIL async_rst_release: got %h expected %h", bus.ReadData1, 32'h0);
      end
      do_write(5'd3, 32'h00000077);
      vectors++;
      if (bus.ReadData1 !== 32'h00000077) begin
         miscompares++; $display("FAIL post_rst_write: got %h expected %h", bus.ReadData1, 32'h00000077);
      end
   endtask

   task automatic test_random();
      logic [31:0] e1;
      logic [31:0] e2;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         bus.RegWrite  = 1'($urandom_range(0, 1));
         bus.WriteReg  = 5'($urandom_range(0, 31));
         bus.WriteData = $urandom;
         bus.ReadReg1  = ($urandom_range(0, 3) == 0) ? bus.WriteReg : 5'($urandom_range(0, 31));
         bus.ReadReg2  = ($urandom_range(0, 3) == 0) ? bus.WriteReg : 5'($urandom_range(0, 31));
         #1;
         e1 = ref_read(bus.ReadReg1);
         e2 = ref_read(bus.ReadReg2);
         vectors++;
         if (bus.ReadData1 !== e1) begin
            miscompares++; $display("FAIL rand_p1 n=%0d a=%0d: got %h expected %h", n, bus.ReadReg1, bus.ReadData1, e1);
         end
         vectors++;
         if (bus.ReadData2 !== e2) begin
            miscompares++; $display("FAIL rand_p2 n=%0d a=%0d: got %h expected %h", n, bus.ReadReg2, bus.ReadData2, e2);
         end
         @(posedge clk); #1;
         if (bus.RegWrite && bus.WriteReg != 5'd0) model[bus.WriteReg] = bus.WriteData;
         bus.RegWrite = 1'b0;
         #1;
         e1 = ref_read(bus.ReadReg1);
         vectors++;
         if (bus.ReadData1 !== e1) begin
            miscompares++; $display("FAIL rand_post n=%0d a=%0d: got %h expected %h", n, bus.ReadReg1, bus.ReadData1, e1);
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      reset = 1'b1;
      vectors = 0;
      miscompares = 0;
      bus.RegWrite = 1'b0; bus.WriteReg = 5'd0; bus.WriteData = 32'h0;
      bus.ReadReg1 = 5'd0; bus.ReadReg2 = 5'd0;
      model_reset();
      test_reset();
      test_write_read();
      test_zero_reg();
      test_no_write();
      test_collision();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
